life_sequencer: RTL and testbench

Generation scheduler for the 8x8 Game of Life core. Owns the current 64-bit grid register and sequences the evolve datapath. Loads a user seed or an LFSR-supplied seed, then issues one evolve request per generation tick (run mode) or per step pulse. Counts generations and halts when the board goes extinct or stops changing; the display path reads `grid` directly.

---
 rtl/life_sequencer_if.sv | 22 ++
 rtl/life_sequencer.sv | 172 +++++++++++++++++
 tb/tb_life_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/life_sequencer_if.sv
// Handshake between the generation sequencer and the evolve datapath.
// master = sequencer side, slave = datapath side.
interface life_sequencer_if;
   logic [63:0] evo_grid;
   logic        evo_start;
   logic [63:0] evo_result;
   logic        evo_done;

   modport master (
      output evo_grid,
      output evo_start,
      input  evo_result,
      input  evo_done
   );

   modport slave (
      input  evo_grid,
      input  evo_start,
      output evo_result,
      output evo_done
   );
endinterface

// File: rtl/life_sequencer.sv
// Generation scheduler for the 8x8 Life core: owns the grid, paces evolve requests, halts on extinction/still life.
// Optional macro LIFE_SEQ_OSC_DETECT_EN adds period-2 oscillator detection as a halt condition.
module life_sequencer #(
   parameter int TICK_DIV = 12_500_000,
   parameter int GEN_W    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [63:0]           seed,
   input  logic                  load,
   input  logic                  reseed,
   input  logic [63:0]           lfsr_seed,
   input  logic                  run,
   input  logic                  step,
   life_sequencer_if.master      evo,
   output logic [63:0]           grid,
   output logic [GEN_W-1:0]      gen_count,
   output logic                  busy,
   output logic                  extinct,
   output logic                  stable
);

   localparam int                TICK_W    = $clog2(TICK_DIV);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, WAIT_TICK, EVOLVE, HALT} state_t;

   typedef struct packed {
      logic        vld;
      logic [63:0] grid;
   } cmd_t;

   state_t              state, state_n;
   logic [63:0]         grid_n;
   logic [63:0]         evo_grid_q, evo_grid_n;
   logic                evo_start_q, evo_start_n;
   logic [GEN_W-1:0]    gen_n;
   logic                stable_n;
   logic [TICK_W-1:0]   tick_cnt, tick_n;
   cmd_t                pend, pend_n, cmd;
   logic                cmd_apply, done_accept;
   logic [63:0]         apply_grid;
   logic                osc_hit;
   logic                res_same;
   logic                halt_now;

`ifdef LIFE_SEQ_OSC_DETECT_EN
   // Generation before the current one; a match against the new result is a period-2 cycle.
   logic [63:0] prev_grid;

   assign osc_hit = (gen_count != '0) && (evo.evo_result == prev_grid);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         prev_grid <= '0;
      else if (cmd_apply)
         prev_grid <= '0;
      else if (done_accept)
         prev_grid <= grid;
   end
`else
   assign osc_hit = 1'b0;
`endif

   assign cmd.vld  = load | reseed;
   assign cmd.grid = load ? seed : lfsr_seed;
   assign res_same = (evo.evo_result == grid);
   assign halt_now = (evo.evo_result == '0) | res_same | osc_hit;

   always_comb begin
      state_n     = state;
      grid_n      = grid;
      gen_n       = gen_count;
      stable_n    = stable;
      tick_n      = tick_cnt;
      pend_n      = pend;
      cmd_apply   = 1'b0;
      done_accept = 1'b0;
      apply_grid  = cmd.grid;

      unique case (state)
         IDLE: begin
            if (step)
               state_n = EVOLVE;
            else if (run)
               state_n = WAIT_TICK;
         end
         WAIT_TICK: begin
            if (step) begin
               state_n = EVOLVE;
               tick_n  = '0;
            end else if (!run) begin
               state_n = IDLE;
               tick_n  = '0;
            end else if (tick_cnt == TICK_LAST) begin
               state_n = EVOLVE;
               tick_n  = '0;
            end else begin
               tick_n  = tick_cnt + 1'b1;
            end
         end
         EVOLVE: begin
            // Commands arriving mid-evolve wait for the datapath; last one wins.
            if (cmd.vld)
               pend_n = cmd;
            if (evo.evo_done) begin
               if (cmd.vld || pend.vld) begin
                  cmd_apply  = 1'b1;
                  apply_grid = cmd.vld ? cmd.grid : pend.grid;
               end else begin
                  done_accept = 1'b1;
                  grid_n      = evo.evo_result;
                  stable_n    = res_same | osc_hit;
                  gen_n       = (&gen_count) ? gen_count : gen_count + 1'b1;
                  if (halt_now)
                     state_n = HALT;
                  else
                     state_n = run ? WAIT_TICK : IDLE;
               end
            end
         end
         HALT: ;
         default: state_n = IDLE;
      endcase

      if (cmd.vld && state != EVOLVE) begin
         cmd_apply  = 1'b1;
         apply_grid = cmd.grid;
      end

      if (cmd_apply) begin
         grid_n   = apply_grid;
         gen_n    = '0;
         stable_n = 1'b0;
         tick_n   = '0;
         pend_n   = '0;
         state_n  = run ? WAIT_TICK : IDLE;
      end
   end

   // Request is registered: it fires in the first EVOLVE cycle only.
   assign evo_start_n = (state_n == EVOLVE) && (state != EVOLVE);
   assign evo_grid_n  = evo_start_n ? grid : evo_grid_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         grid        <= '0;
         gen_count   <= '0;
         stable      <= 1'b0;
         tick_cnt    <= '0;
         pend        <= '0;
         evo_grid_q  <= '0;
         evo_start_q <= 1'b0;
      end else begin
         state       <= state_n;
         grid        <= grid_n;
         gen_count   <= gen_n;
         stable      <= stable_n;
         tick_cnt    <= tick_n;
         pend        <= pend_n;
         evo_grid_q  <= evo_grid_n;
         evo_start_q <= evo_start_n;
      end
   end

   assign evo.evo_grid  = evo_grid_q;
   assign evo.evo_start = evo_start_q;
   assign busy          = (state == EVOLVE);
   assign extinct       = (grid == '0);

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer: table of step scenarios plus hand sequences for run mode, mid-evolve load and reset.
module tb_life_sequencer;

   logic        clk;
   logic        reset;
   logic [63:0] seed;
   logic        load;
   logic        reseed;
   logic [63:0] lfsr_seed;
   logic        run;
   logic        step;
   logic [63:0] grid;
   logic [15:0] gen_count;
   logic        busy;
   logic        extinct;
   logic        stable;

   life_sequencer_if evo_if ();

   life_sequencer #(.TICK_DIV(4), .GEN_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .seed      (seed),
      .load      (load),
      .reseed    (reseed),
      .lfsr_seed (lfsr_seed),
      .run       (run),
      .step      (step),
      .evo       (evo_if),
      .grid      (grid),
      .gen_count (gen_count),
      .busy      (busy),
      .extinct   (extinct),
      .stable    (stable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int start_cnt = 0;

   // Reference Life rule, dead cells beyond the 8x8 edge.
   function automatic logic [63:0] life(input logic [63:0] g);
      logic [63:0] n;
      int cnt, rr, cc;
      n = '0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++) begin
                  rr = r + dr;
                  cc = c + dc;
                  if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                     if (g[rr*8+cc]) cnt++;
               end
            n[r*8+c] = g[r*8+c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
         end
      return n;
   endfunction

   // Datapath model: 3-cycle latency from evo_start to evo_done; not reset, so late results can land.
   logic [63:0] dp_grid;
   int          dp_cnt = 0;
   initial begin
      evo_if.evo_done   = 1'b0;
      evo_if.evo_result = '0;
   end
   always begin
      @(posedge clk);
      #2;
      evo_if.evo_done = 1'b0;
      if (dp_cnt > 0) begin
         dp_cnt--;
         if (dp_cnt == 0) begin
            evo_if.evo_done   = 1'b1;
            evo_if.evo_result = life(dp_grid);
         end
      end
      if (evo_if.evo_start) begin
         start_cnt++;
         dp_grid = evo_if.evo_grid;
         dp_cnt  = 3;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input logic [63:0] s, input logic r);
      seed = s;
      run  = r;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic do_step();
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      cyc(8);
   endtask

   typedef struct {
      logic [63:0] seed;
      int          steps;
      logic [63:0] exp_grid;
      logic [15:0] exp_gen;
      logic        exp_stable;
      logic        exp_extinct;
   } vec_t;

   vec_t vt[7];
   int   sc;
   bit   seen;

   initial begin
      vt[0] = '{64'h700,   1, 64'h20202, 16'd1, 1'b0, 1'b0};
      vt[1] = '{64'h303,   1, 64'h303,   16'd1, 1'b1, 1'b0};
      vt[2] = '{64'h1,     1, 64'h0,     16'd1, 1'b0, 1'b1};
      vt[3] = '{64'h303,   3, 64'h303,   16'd1, 1'b1, 1'b0};
      vt[4] = '{64'h0,     2, 64'h0,     16'd1, 1'b1, 1'b1};
      vt[5] = '{64'h301,   1, 64'h303,   16'd1, 1'b0, 1'b0};
`ifdef LIFE_SEQ_OSC_DETECT_EN
      vt[6] = '{64'h700,   3, 64'h700,   16'd2, 1'b1, 1'b0};
`else
      vt[6] = '{64'h700,   3, 64'h20202, 16'd3, 1'b0, 1'b0};
`endif

      reset = 1'b0; seed = '0; load = 1'b0; reseed = 1'b0;
      lfsr_seed = '0; run = 1'b0; step = 1'b0;
      cyc(3);
      chk("reset grid", grid, 0);
      chk("reset gen_count", gen_count, 0);
      chk("reset evo_start", evo_if.evo_start, 0);
      chk("reset busy", busy, 0);
      chk("reset stable", stable, 0);
      chk("reset extinct", extinct, 1);
      chk("reset evo_grid", evo_if.evo_grid, 0);
      reset = 1'b1;
      cyc(2);

      // Load blinker, no run: nothing is requested.
      sc = start_cnt;
      do_load(64'h700, 1'b0);
      cyc(4);
      chk("load grid", grid, 64'h700);
      chk("load gen_count", gen_count, 0);
      chk("load extinct", extinct, 0);
      chk("load no evo_start", start_cnt, sc);

      // Step timing: request in the cycle right after the step pulse.
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      chk("step evo_start", evo_if.evo_start, 1);
      chk("step busy", busy, 1);
      chk("step evo_grid", evo_if.evo_grid, 64'h700);
      @(negedge clk);
      chk("step evo_start one cycle", evo_if.evo_start, 0);
      cyc(6);
      chk("step grid", grid, 64'h20202);
      chk("step gen_count", gen_count, 1);
      chk("step back to idle", busy, 0);
      chk("step single request", start_cnt, sc + 1);

      for (int i = 0; i < 7; i++) begin
         do_load(vt[i].seed, 1'b0);
         for (int k = 0; k < vt[i].steps; k++) do_step();
         chk($sformatf("vec%0d grid", i), grid, vt[i].exp_grid);
         chk($sformatf("vec%0d gen_count", i), gen_count, vt[i].exp_gen);
         chk($sformatf("vec%0d stable", i), stable, vt[i].exp_stable);
         chk($sformatf("vec%0d extinct", i), extinct, vt[i].exp_extinct);
      end

      // Run mode on a still life: halts after one generation, then ignores step and run.
      do_load(64'h303, 1'b1);
      cyc(12);
      chk("run block stable", stable, 1);
      chk("run block gen_count", gen_count, 1);
      chk("run block halted", busy, 0);
      sc = start_cnt;
      do_step();
      chk("halt step ignored gen", gen_count, 1);
      chk("halt step no request", start_cnt, sc);
      run = 1'b0;

      // Extinction then reseed.
      do_load(64'h1, 1'b0);
      do_step();
      chk("single extinct", extinct, 1);
      lfsr_seed = 64'hACE1;
      reseed = 1'b1;
      @(negedge clk);
      reseed = 1'b0;
      cyc(1);
      chk("reseed grid", grid, 64'hACE1);
      chk("reseed gen_count", gen_count, 0);
      chk("reseed stable", stable, 0);

      // Load during EVOLVE: result discarded, new seed lands after evo_done.
      do_load(64'h700, 1'b0);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      seed = 64'h303;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("mid-evolve grid held", grid, 64'h700);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (evo_if.evo_done) seen = 1'b1;
         else @(negedge clk);
      end
      chk("mid-evolve done seen", seen, 1);
      @(negedge clk);
      chk("mid-evolve new seed", grid, 64'h303);
      chk("mid-evolve gen_count", gen_count, 0);
      chk("mid-evolve idle", busy, 0);

      // Blinker under run.
      do_load(64'h700, 1'b1);
`ifdef LIFE_SEQ_OSC_DETECT_EN
      cyc(60);
      chk("osc gen_count", gen_count, 2);
      chk("osc stable", stable, 1);
      chk("osc halted", busy, 0);
`else
      for (int i = 0; i < 300 && gen_count < 16'd10; i++) @(negedge clk);
      chk("blinker gen_count", gen_count, 10);
      chk("blinker stable", stable, 0);
`endif

      // Reset mid-evolve, then a late evo_done must be ignored.
      do_load(64'h700, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         if (busy) seen = 1'b1;
         else @(negedge clk);
      end
      chk("reach evolve", seen, 1);
      reset = 1'b0;
      run   = 1'b0;
      #1;
      chk("abort grid", grid, 0);
      chk("abort gen_count", gen_count, 0);
      chk("abort evo_start", evo_if.evo_start, 0);
      chk("abort busy", busy, 0);
      chk("abort stable", stable, 0);
      chk("abort extinct", extinct, 1);
      chk("abort evo_grid", evo_if.evo_grid, 0);
      @(negedge clk);
      reset = 1'b1;
      cyc(6);
      chk("late done grid", grid, 0);
      chk("late done gen_count", gen_count, 0);
      chk("late done idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
